// File: rtl/bpm_pos_scan.sv
// Frame-triggered scan of the SDI DPRAM that splits the BPM X/Y words into two
// BRAM write streams. Disabled cells are zero-filled so matrix columns stay fixed.
module bpm_pos_scan #(
  parameter int MAX_CELLS = 30,
  parameter int ADDR_W    = 10,
  parameter int OUT_AW    = 9,
  parameter int DW        = 32,
  parameter int RAM_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trig,
  input  logic [4:0]           cell_count,
  input  logic [4:0]           sig_per_cell,
  input  logic [4:0]           bpm_per_cell,
  input  logic [MAX_CELLS-1:0] cell_enable,
  output logic                 ram_rd,
  output logic [ADDR_W-1:0]    ram_addr,
  input  logic [DW-1:0]        ram_dout,
  output logic                 bram_x_wr,
  output logic                 bram_y_wr,
  output logic [OUT_AW-1:0]    bram_x_addr,
  output logic [OUT_AW-1:0]    bram_y_addr,
  output logic [DW-1:0]        bram_x_din,
  output logic [DW-1:0]        bram_y_din,
  output logic [4:0]           cell_cnt,
  output logic                 cell_mark,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          overrun_cnt,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH, S_DONE} state_t;

  typedef struct packed {
    logic vld;
    logic bpm;
    logic is_x;
    logic en;
    logic first;
  } tag_t;

  state_t            state_q;
  logic [4:0]        cc_q, spc_q, bpc_q;
  logic [4:0]        w_q, c_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic [2:0]        flush_q;
  logic              busy_q, done_q;
  logic [15:0]       ovr_q;
  tag_t              pipe_q [RAM_LAT];
  logic              x_wr_q, y_wr_q, mark_q;
  logic [OUT_AW-1:0] x_addr_q, y_addr_q, x_next_q, y_next_q;
  logic [DW-1:0]     x_din_q, y_din_q;

  logic [4:0]        cc_d, spc_d, bpc_d, bpc_raw;
  logic              degen_d, last_word, last_cell, is_busy;
  logic              x_wr_d, y_wr_d, mark_d;
  logic [DW-1:0]     din_d;
  tag_t              tag_d, tag_out;

  always_comb begin
    cc_d      = (cell_count > 5'(MAX_CELLS)) ? 5'(MAX_CELLS) : cell_count;
    bpc_raw   = (bpm_per_cell > sig_per_cell) ? sig_per_cell : bpm_per_cell;
    spc_d     = {sig_per_cell[4:1], 1'b0};
    bpc_d     = {bpc_raw[4:1], 1'b0};
    degen_d   = (cc_d == 5'd0) || (spc_d == 5'd0);
    last_word = (w_q == spc_q - 5'd1);
    last_cell = (c_q == cc_q - 5'd1);
    is_busy   = (state_q == S_SCAN) || (state_q == S_FLUSH);

    // Tag describes the read presented this cycle; it travels alongside the RAM latency.
    tag_d       = '0;
    tag_d.vld   = rd_q;
    tag_d.bpm   = (w_q < bpc_q);
    tag_d.is_x  = ~w_q[0];
    tag_d.en    = cell_enable[c_q];
    tag_d.first = (w_q == 5'd0);

    tag_out = pipe_q[RAM_LAT-1];
    // A trig this cycle discards whatever is still in flight.
    x_wr_d  = tag_out.vld & tag_out.bpm & tag_out.is_x & ~trig;
    y_wr_d  = tag_out.vld & tag_out.bpm & ~tag_out.is_x & ~trig;
    mark_d  = tag_out.vld & tag_out.bpm & tag_out.first & ~trig;
    din_d   = tag_out.en ? ram_dout : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cc_q     <= '0;
      spc_q    <= '0;
      bpc_q    <= '0;
      w_q      <= '0;
      c_q      <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      flush_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= '0;
      x_wr_q   <= 1'b0;
      y_wr_q   <= 1'b0;
      mark_q   <= 1'b0;
      x_addr_q <= '0;
      y_addr_q <= '0;
      x_next_q <= '0;
      y_next_q <= '0;
      x_din_q  <= '0;
      y_din_q  <= '0;
      for (int i = 0; i < RAM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      x_wr_q <= x_wr_d;
      y_wr_q <= y_wr_d;
      mark_q <= mark_d;
      if (x_wr_d) begin
        x_addr_q <= x_next_q;
        x_din_q  <= din_d;
        x_next_q <= x_next_q + OUT_AW'(1);
      end
      if (y_wr_d) begin
        y_addr_q <= y_next_q;
        y_din_q  <= din_d;
        y_next_q <= y_next_q + OUT_AW'(1);
      end
      pipe_q[0] <= tag_d;
      for (int i = 1; i < RAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      done_q <= 1'b0;

      if (trig) begin
        if (is_busy && ovr_q != 16'hFFFF) ovr_q <= ovr_q + 16'd1;
        cc_q     <= cc_d;
        spc_q    <= spc_d;
        bpc_q    <= bpc_d;
        w_q      <= '0;
        c_q      <= '0;
        addr_q   <= '0;
        flush_q  <= '0;
        x_next_q <= '0;
        y_next_q <= '0;
        for (int i = 0; i < RAM_LAT; i++) pipe_q[i] <= '0;
        if (degen_d) begin
          state_q <= S_DONE;
          rd_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= S_SCAN;
          rd_q    <= 1'b1;
          busy_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          S_SCAN: begin
            if (last_word && last_cell) begin
              state_q <= S_FLUSH;
              rd_q    <= 1'b0;
              flush_q <= '0;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
              if (last_word) begin
                w_q <= '0;
                c_q <= c_q + 5'd1;
              end else begin
                w_q <= w_q + 5'd1;
              end
            end
          end
          S_FLUSH: begin
            if (flush_q == 3'(RAM_LAT)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              flush_q <= flush_q + 3'd1;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ram_rd      = rd_q;
  assign ram_addr    = addr_q;
  assign bram_x_wr   = x_wr_q;
  assign bram_y_wr   = y_wr_q;
  assign bram_x_addr = x_addr_q;
  assign bram_y_addr = y_addr_q;
  assign bram_x_din  = x_din_q;
  assign bram_y_din  = y_din_q;
  assign cell_cnt    = c_q;
  assign cell_mark   = mark_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun_cnt = ovr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_bpm_pos_scan.sv
// Directed bench for bpm_pos_scan: a latency-modelled DPRAM returning its own
// address, a negedge monitor logging reads/writes, and one task per scenario.
module tb_bpm_pos_scan;
  localparam int MAX_CELLS = 30;
  localparam int ADDR_W    = 10;
  localparam int OUT_AW    = 9;
  localparam int DW        = 32;
  localparam int RAM_LAT   = 2;

  typedef logic [OUT_AW+DW-1:0] wr_t;

  logic                 clk, reset, trig;
  logic [4:0]           cell_count, sig_per_cell, bpm_per_cell;
  logic [MAX_CELLS-1:0] cell_enable;
  logic                 ram_rd;
  logic [ADDR_W-1:0]    ram_addr;
  logic [DW-1:0]        ram_dout;
  logic                 bram_x_wr, bram_y_wr;
  logic [OUT_AW-1:0]    bram_x_addr, bram_y_addr;
  logic [DW-1:0]        bram_x_din, bram_y_din;
  logic [4:0]           cell_cnt;
  logic                 cell_mark, busy, done;
  logic [15:0]          overrun_cnt;
  logic [1:0]           dbg_state;
  logic [120:0]         all_outs;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int trig_cyc, first_rd_cyc, last_rd_cyc, first_x_cyc, done_cyc;
  int done_cnt, mark_cnt, busy_err, max_cc;
  logic [ADDR_W-1:0] rd_log_q[$];
  wr_t got_x_q[$], got_y_q[$], exp_x_q[$], exp_y_q[$];
  logic [ADDR_W-1:0] ram_dly [RAM_LAT];

  bpm_pos_scan #(
    .MAX_CELLS(MAX_CELLS), .ADDR_W(ADDR_W), .OUT_AW(OUT_AW), .DW(DW), .RAM_LAT(RAM_LAT)
  ) dut (
    .clk(clk), .reset(reset), .trig(trig),
    .cell_count(cell_count), .sig_per_cell(sig_per_cell), .bpm_per_cell(bpm_per_cell),
    .cell_enable(cell_enable),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .bram_x_wr(bram_x_wr), .bram_y_wr(bram_y_wr),
    .bram_x_addr(bram_x_addr), .bram_y_addr(bram_y_addr),
    .bram_x_din(bram_x_din), .bram_y_din(bram_y_din),
    .cell_cnt(cell_cnt), .cell_mark(cell_mark), .busy(busy), .done(done),
    .overrun_cnt(overrun_cnt), .dbg_state(dbg_state)
  );

  assign all_outs = {ram_rd, ram_addr, bram_x_wr, bram_y_wr, bram_x_addr, bram_y_addr,
                     bram_x_din, bram_y_din, cell_cnt, cell_mark, busy, done,
                     overrun_cnt, dbg_state};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // DPRAM model: data word equals the address presented RAM_LAT clocks earlier.
  always @(posedge clk) begin
    ram_dly[0] <= ram_addr;
    for (int i = 1; i < RAM_LAT; i++) ram_dly[i] <= ram_dly[i-1];
  end
  assign ram_dout = {{(DW-ADDR_W){1'b0}}, ram_dly[RAM_LAT-1]};

  // monitor
  always @(negedge clk) begin
    cyc++;
    if (ram_rd === 1'b1) begin
      if (rd_log_q.size() == 0) first_rd_cyc = cyc;
      rd_log_q.push_back(ram_addr);
      last_rd_cyc = cyc;
    end
    if (bram_x_wr === 1'b1) begin
      if (got_x_q.size() == 0) first_x_cyc = cyc;
      got_x_q.push_back({bram_x_addr, bram_x_din});
    end
    if (bram_y_wr === 1'b1) got_y_q.push_back({bram_y_addr, bram_y_din});
    if (cell_mark === 1'b1) mark_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if ((ram_rd === 1'b1 || bram_x_wr === 1'b1 || bram_y_wr === 1'b1) && busy !== 1'b1)
      busy_err++;
    if (busy === 1'b1 && int'(cell_cnt) > max_cc) max_cc = int'(cell_cnt);
  end

  // driver tasks
  task automatic clear_wr();
    rd_log_q.delete();
    got_x_q.delete();
    got_y_q.delete();
    mark_cnt     = 0;
    busy_err     = 0;
    max_cc       = 0;
    first_rd_cyc = -1;
    last_rd_cyc  = -1;
    first_x_cyc  = -1;
  endtask

  task automatic set_cfg(input int cc, input int spc, input int bpc,
                         input logic [MAX_CELLS-1:0] en);
    cell_count   = 5'(cc);
    sig_per_cell = 5'(spc);
    bpm_per_cell = 5'(bpc);
    cell_enable  = en;
  endtask

  task automatic pulse_trig();
    @(negedge clk);
    #1;
    clear_wr();
    trig     = 1'b1;
    trig_cyc = cyc;
    @(negedge clk);
    #1;
    trig = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (done_cnt != 0);
    repeat (6) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic wr_t pk(input int a, input int d);
    return {OUT_AW'(a), DW'(d)};
  endfunction

  // -1 on a length difference, else the number of differing entries.
  function automatic int diff_wr(input bit y_axis);
    int n = 0;
    if (y_axis) begin
      if (got_y_q.size() != exp_y_q.size()) return -1;
      foreach (got_y_q[i]) if (got_y_q[i] !== exp_y_q[i]) n++;
    end else begin
      if (got_x_q.size() != exp_x_q.size()) return -1;
      foreach (got_x_q[i]) if (got_x_q[i] !== exp_x_q[i]) n++;
    end
    return n;
  endfunction

  // Full-frame reference: X of cell c, pair k lands at c*(bpc/2)+k with word c*spc+2k.
  task automatic build_full_exp(input int cc, input int spc, input int bpc);
    exp_x_q.delete();
    exp_y_q.delete();
    for (int c = 0; c < cc; c++)
      for (int k = 0; k < bpc / 2; k++) begin
        exp_x_q.push_back(pk(c * (bpc / 2) + k, c * spc + 2 * k));
        exp_y_q.push_back(pk(c * (bpc / 2) + k, c * spc + 2 * k + 1));
      end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    trig  = 1'b0;
    set_cfg(0, 0, 0, '0);
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    reset = 1'b0;
    clear_wr();
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (rd_log_q.size() != 0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL idle_quiet: reads=%0d state=%0d expected 0 reads, state 0",
               rd_log_q.size(), dbg_state);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int n = 0;
    set_cfg(2, 4, 2, '1);
    done_cnt = 0;
    pulse_trig();
    wait_done(40, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_timeout: no done within 40 clocks");
    end
    foreach (rd_log_q[i]) if (rd_log_q[i] !== ADDR_W'(i)) n++;
    total++;
    if (rd_log_q.size() != 8 || n != 0) begin
      bad++;
      $display("FAIL basic_addr_seq: reads=%0d bad_addr=%0d expected 8 reads 0..7",
               rd_log_q.size(), n);
    end
    total++;
    if (first_rd_cyc != trig_cyc + 1 || last_rd_cyc - first_rd_cyc != 7) begin
      bad++;
      $display("FAIL basic_rd_timing: first=%0d last=%0d expected first=%0d last=%0d",
               first_rd_cyc, last_rd_cyc, trig_cyc + 1, trig_cyc + 8);
    end
    exp_x_q = '{pk(0, 0), pk(1, 4)};
    exp_y_q = '{pk(0, 1), pk(1, 5)};
    total++;
    if (diff_wr(0) != 0) begin
      bad++;
      $display("FAIL basic_x_writes: count=%0d diff=%0d expected 2 entries (0,0),(1,4)",
               got_x_q.size(), diff_wr(0));
    end
    total++;
    if (diff_wr(1) != 0) begin
      bad++;
      $display("FAIL basic_y_writes: count=%0d diff=%0d expected 2 entries (0,1),(1,5)",
               got_y_q.size(), diff_wr(1));
    end
    total++;
    if (first_x_cyc - first_rd_cyc != RAM_LAT + 1) begin
      bad++;
      $display("FAIL basic_wr_latency: got %0d expected %0d",
               first_x_cyc - first_rd_cyc, RAM_LAT + 1);
    end
    total++;
    if (mark_cnt != 2) begin
      bad++;
      $display("FAIL basic_cell_mark: got %0d expected 2", mark_cnt);
    end
    total++;
    if (done_cnt != 1 || done_cyc - last_rd_cyc != RAM_LAT + 2) begin
      bad++;
      $display("FAIL basic_done: count=%0d delay=%0d expected count=1 delay=%0d",
               done_cnt, done_cyc - last_rd_cyc, RAM_LAT + 2);
    end
    total++;
    if (busy !== 1'b0 || busy_err != 0) begin
      bad++;
      $display("FAIL basic_busy: busy=%b busy_gaps=%0d expected 0 and 0", busy, busy_err);
    end
  endtask

  task automatic test_disabled();
    bit ok;
    set_cfg(2, 4, 2, 30'b01);
    done_cnt = 0;
    pulse_trig();
    wait_done(40, ok);
    exp_x_q = '{pk(0, 0), pk(1, 0)};
    exp_y_q = '{pk(0, 1), pk(1, 0)};
    total++;
    if (!ok || diff_wr(0) != 0 || diff_wr(1) != 0) begin
      bad++;
      $display("FAIL disabled_zero_fill: done=%0b xdiff=%0d ydiff=%0d expected 1,0,0",
               ok, diff_wr(0), diff_wr(1));
    end
    total++;
    if (mark_cnt != 2) begin
      bad++;
      $display("FAIL disabled_cell_mark: got %0d expected 2", mark_cnt);
    end
  endtask

  task automatic test_full();
    bit ok;
    set_cfg(26, 30, 24, '1);
    done_cnt = 0;
    pulse_trig();
    wait_done(1000, ok);
    build_full_exp(26, 30, 24);
    total++;
    if (!ok || rd_log_q.size() != 780) begin
      bad++;
      $display("FAIL full_reads: done=%0b reads=%0d expected 1 and 780", ok, rd_log_q.size());
    end
    total++;
    if (diff_wr(0) != 0 || diff_wr(1) != 0) begin
      bad++;
      $display("FAIL full_writes: x=%0d y=%0d xdiff=%0d ydiff=%0d expected 312/312 no diffs",
               got_x_q.size(), got_y_q.size(), diff_wr(0), diff_wr(1));
    end
    total++;
    if (bram_x_addr !== 9'd311 || bram_y_addr !== 9'd311) begin
      bad++;
      $display("FAIL full_last_addr: x=%0d y=%0d expected 311", bram_x_addr, bram_y_addr);
    end
    total++;
    if (max_cc != 25 || busy_err != 0 || done_cnt != 1 || mark_cnt != 26) begin
      bad++;
      $display("FAIL full_status: cell_max=%0d gaps=%0d done=%0d marks=%0d expected 25,0,1,26",
               max_cc, busy_err, done_cnt, mark_cnt);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    set_cfg(26, 30, 24, '1);
    done_cnt = 0;
    pulse_trig();
    while (cyc < trig_cyc + 100) begin
      @(negedge clk);
      #1;
    end
    pulse_trig();
    wait_done(1000, ok);
    build_full_exp(26, 30, 24);
    total++;
    if (overrun_cnt !== 16'd1) begin
      bad++;
      $display("FAIL overrun_count: got %0d expected 1", overrun_cnt);
    end
    total++;
    if (!ok || done_cnt != 1) begin
      bad++;
      $display("FAIL overrun_done: got %0d pulses expected 1", done_cnt);
    end
    total++;
    if (rd_log_q.size() != 780 || first_rd_cyc != trig_cyc + 1 || rd_log_q[0] !== '0) begin
      bad++;
      $display("FAIL overrun_restart: reads=%0d first_cyc=%0d expected 780 from addr 0 at %0d",
               rd_log_q.size(), first_rd_cyc, trig_cyc + 1);
    end
    total++;
    if (diff_wr(0) != 0 || diff_wr(1) != 0) begin
      bad++;
      $display("FAIL overrun_writes: x=%0d y=%0d xdiff=%0d ydiff=%0d expected clean 312/312",
               got_x_q.size(), got_y_q.size(), diff_wr(0), diff_wr(1));
    end
  endtask

  task automatic test_degenerate();
    bit ok;
    set_cfg(0, 4, 2, '1);
    done_cnt = 0;
    pulse_trig();
    wait_done(10, ok);
    total++;
    if (!ok || done_cyc - trig_cyc > 3 || done_cnt != 1) begin
      bad++;
      $display("FAIL degen_done: done=%0b delay=%0d count=%0d expected delay<=3 count=1",
               ok, done_cyc - trig_cyc, done_cnt);
    end
    total++;
    if (rd_log_q.size() != 0 || got_x_q.size() != 0 || got_y_q.size() != 0) begin
      bad++;
      $display("FAIL degen_quiet: reads=%0d x=%0d y=%0d expected 0",
               rd_log_q.size(), got_x_q.size(), got_y_q.size());
    end
    set_cfg(2, 4, 31, '1);
    done_cnt = 0;
    pulse_trig();
    wait_done(40, ok);
    exp_x_q = '{pk(0, 0), pk(1, 2), pk(2, 4), pk(3, 6)};
    exp_y_q = '{pk(0, 1), pk(1, 3), pk(2, 5), pk(3, 7)};
    total++;
    if (!ok || diff_wr(0) != 0 || diff_wr(1) != 0) begin
      bad++;
      $display("FAIL clamp_bpm: done=%0b x=%0d y=%0d xdiff=%0d ydiff=%0d expected 4/4 no diffs",
               ok, got_x_q.size(), got_y_q.size(), diff_wr(0), diff_wr(1));
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_cfg(26, 30, 24, '1);
    done_cnt = 0;
    pulse_trig();
    while (cyc < trig_cyc + 50) begin
      @(negedge clk);
      #1;
    end
    reset = 1'b1;
    clear_wr();
    @(negedge clk);
    #1;
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got %h expected 0", all_outs);
    end
    reset = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    total++;
    if (done_cnt != 0 || rd_log_q.size() != 0 || got_x_q.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_abort: done=%0d reads=%0d xw=%0d expected 0",
               done_cnt, rd_log_q.size(), got_x_q.size());
    end
    set_cfg(2, 4, 2, '1);
    pulse_trig();
    wait_done(40, ok);
    exp_x_q = '{pk(0, 0), pk(1, 4)};
    exp_y_q = '{pk(0, 1), pk(1, 5)};
    total++;
    if (!ok || done_cnt != 1 || diff_wr(0) != 0 || diff_wr(1) != 0) begin
      bad++;
      $display("FAIL reset_mid_next_frame: done=%0d xdiff=%0d ydiff=%0d expected 1,0,0",
               done_cnt, diff_wr(0), diff_wr(1));
    end
  endtask

  initial begin
    done_cnt = 0;
    clear_wr();
    test_reset();
    test_basic();
    test_disabled();
    test_full();
    test_overrun();
    test_degenerate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
